// File: rtl/haze_video_pkg.sv
// haze_video_pkg: shared VGA timing constants, pixel type and fetch FSM states
package haze_video_pkg;
    localparam int H_TOTAL    = 800;
    localparam int H_ACTIVE   = 640;
    localparam int V_TOTAL    = 525;
    localparam int V_ACTIVE   = 480;
    localparam int FETCH_LINE = 522;
    typedef logic [7:0] rgb332_t;
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_state_t;
endpackage

// File: rtl/vga_line_buffer.sv
// vga_line_buffer: two-bank source-row buffer, 32-bit word write port, 8-bit registered read port
module vga_line_buffer
    import haze_video_pkg::*;
#(
    parameter int SRC_W = 320,
    localparam int CW = $clog2(SRC_W)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic [CW-3:0] wr_word,
    input  logic [31:0]   wr_data,
    input  logic          rd_bank,
    input  logic [CW-1:0] rd_col,
    output rgb332_t       rd_data
);
    rgb332_t ram [2][SRC_W];
    // a word write fills four consecutive columns, lowest column in the low byte
    always_ff @(posedge clk) begin
        if (wr_en)
            for (int i = 0; i < 4; i++) ram[wr_bank][{wr_word, 2'(i)}] <= wr_data[8*i +: 8];
    end
    // synchronous read, one cycle of latency
    always_ff @(posedge clk) begin
        rd_data <= ram[rd_bank][rd_col];
    end
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: 2x-scaled 320x240 RGB332 scanout with ping-pong row prefetch
module vga_scanout
    import haze_video_pkg::*;
#(
    parameter int unsigned FB_BASE = 24'h000000,
    parameter int          SRC_W   = 320,
    parameter int          SRC_H   = 240,
    parameter int          ADDR_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_hsync,
    input  logic              vga_vsync,
    input  logic              vga_de,
    input  logic [9:0]        vga_line,
    input  logic [9:0]        vga_pixel,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              out_hsync,
    output logic              out_vsync,
    output logic              out_de,
    output rgb332_t           out_rgb,
    output logic              underrun
);
    localparam int CW = $clog2(SRC_W);
    localparam logic [CW-3:0] LAST = (CW-2)'(SRC_W/4 - 1);
    localparam logic [CW-3:0] W1 = (CW-2)'(1);
    fetch_state_t      state;
    logic [7:0]        row;
    logic [CW-3:0]     word;
    logic [CW-3:0]     rsp;
    logic              trig;
    logic [7:0]        trig_row;
    logic [ADDR_W-1:0] trig_addr;
    logic [CW-1:0]     rd_col;
    rgb332_t           rd_q;
    logic              hs_d1;
    logic              vs_d1;
    logic              de_d1;
    // fetch trigger: row 0 on the fetch line, else the row after the one shown on each even active line
    always_comb begin
        trig      = vga_pixel == 10'd0 && (vga_line == 10'(FETCH_LINE) ||
                    (!vga_line[0] && vga_line < 10'(V_ACTIVE) && int'(vga_line >> 1) + 1 < SRC_H));
        trig_row  = vga_line == 10'(FETCH_LINE) ? 8'd0 : 8'(vga_line[9:1]) + 8'd1;
        trig_addr = ADDR_W'(FB_BASE) + ADDR_W'(trig_row) * ADDR_W'(SRC_W);
        rd_col    = vga_de ? CW'(vga_pixel >> 1) : '0;
    end
    // row fetch FSM: issue SRC_W/4 word reads, then wait for the last response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            row      <= '0;
            word     <= '0;
            rsp      <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            underrun <= 1'b0;
        end else begin
            if (trig && state != IDLE) underrun <= 1'b1;
            if (state != IDLE && mem_rvalid) rsp <= rsp + W1;
            if (state == IDLE && trig) begin
                state    <= REQ;
                row      <= trig_row;
                word     <= '0;
                rsp      <= '0;
                mem_req  <= 1'b1;
                mem_addr <= trig_addr;
            end else if (state == REQ && mem_gnt) begin
                word     <= word + W1;
                mem_addr <= mem_addr + ADDR_W'(4);
                if (word == LAST) begin
                    state   <= DRAIN;
                    mem_req <= 1'b0;
                end
            end else if (state == DRAIN && mem_rvalid && rsp == LAST) begin
                state <= IDLE;
            end
        end
    end
    vga_line_buffer #(.SRC_W(SRC_W)) u_buf (
        .clk     (clk),
        .wr_en   (mem_rvalid && state != IDLE),
        .wr_bank (row[0]),
        .wr_word (rsp),
        .wr_data (mem_rdata),
        .rd_bank (vga_line[1]),
        .rd_col  (rd_col),
        .rd_data (rd_q)
    );
    // two-stage output pipeline keeps syncs aligned with the buffer read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_d1     <= 1'b0;
            vs_d1     <= 1'b0;
            de_d1     <= 1'b0;
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
            out_de    <= 1'b0;
            out_rgb   <= '0;
        end else begin
            hs_d1     <= vga_hsync;
            vs_d1     <= vga_vsync;
            de_d1     <= vga_de;
            out_hsync <= hs_d1;
            out_vsync <= vs_d1;
            out_de    <= de_d1;
            out_rgb   <= de_d1 ? rd_q : '0;
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: scanout bench with compressed timing, memory model and image/fetch model
module tb_vga_scanout;
    localparam int FB_BASE = 0;
    typedef struct {logic [23:0] addr; int due;} rsp_t;
    logic        clk = 0;
    logic        reset = 1;
    logic        vga_hsync = 1;
    logic        vga_vsync = 1;
    logic        vga_de = 0;
    logic [9:0]  vga_line = 10'd523;
    logic [9:0]  vga_pixel = 10'd780;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_gnt = 0;
    logic        mem_rvalid = 0;
    logic [31:0] mem_rdata = 0;
    logic        out_hsync;
    logic        out_vsync;
    logic        out_de;
    logic [7:0]  out_rgb;
    logic        underrun;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gmode = 0;
    int lat = 1;
    int rst_hold = 0;
    bit arm37 = 0;
    bit busy = 0;
    int frow = 0;
    int fk = 0;
    int frsp = 0;
    bit exp_ur = 0;
    int bank_row [2] = '{-1, -1};
    bit nogo_prev = 0;
    logic [23:0] addr_prev = 0;
    rsp_t rq [$];
    int l2 [640];
    int l3 [640];
    int pin_a = -1;
    int pin_b = -1;

    vga_scanout #(.FB_BASE(FB_BASE), .SRC_W(320), .SRC_H(240), .ADDR_W(24)) dut (
        .clk(clk), .reset(reset), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de),
        .vga_line(vga_line), .vga_pixel(vga_pixel), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .out_hsync(out_hsync),
        .out_vsync(out_vsync), .out_de(out_de), .out_rgb(out_rgb), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input longint a, input longint e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (line %0d pixel %0d)", n, a, e, vga_line, vga_pixel);
        end
    endtask

    function automatic logic [31:0] fb_word(input logic [23:0] a);
        int off = int'(a) - FB_BASE;
        int y = off / 320;
        int x = off % 320;
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'((x + i + y) & 255);
        return w;
    endfunction

    task automatic step(input int l, input int p);
        rsp_t r;
        @(negedge clk);
        cyc++;
        if (arm37 && busy && fk == 37 && mem_req) begin
            rst_hold = 3;
            arm37 = 0;
        end
        if (rst_hold > 0) begin
            reset = 1;
            rst_hold--;
        end else reset = 0;
        vga_line  = 10'(l);
        vga_pixel = 10'(p);
        vga_de    = p < 640 && l < 480;
        vga_hsync = !(p >= 656 && p < 752);
        vga_vsync = !(l == 490 || l == 491);
        mem_rvalid = 0;
        mem_rdata  = 0;
        mem_gnt    = 0;
        if (reset) begin
            rq.delete();
            busy = 0;
            exp_ur = 0;
            bank_row[0] = -1;
            bank_row[1] = -1;
            nogo_prev = 0;
            return;
        end
        chk("mem_req", mem_req, busy && fk < 80);
        if (p == 0 && (l == 522 || (l % 2 == 0 && l < 480 && l / 2 + 1 < 240))) begin
            if (busy) exp_ur = 1;
            else begin
                busy = 1;
                frow = l == 522 ? 0 : l / 2 + 1;
                fk = 0;
                frsp = 0;
                bank_row[frow % 2] = -1;
            end
        end
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            mem_rvalid = 1;
            mem_rdata  = fb_word(r.addr);
            frsp++;
            if (frsp == 80) begin
                busy = 0;
                bank_row[frow % 2] = frow;
            end
        end
        mem_gnt = gmode == 0 ? 1'b1 : gmode == 1 ? (cyc % 4 == 0) : 1'b0;
        if (nogo_prev && mem_req) chk("addr_hold", mem_addr, addr_prev);
        if (mem_req && mem_gnt) begin
            chk("addr", mem_addr, FB_BASE + frow * 320 + 4 * fk);
            fk++;
            rq.push_back('{mem_addr, cyc + lat});
        end
        nogo_prev = mem_req && !mem_gnt;
        addr_prev = mem_addr;
    endtask

    task automatic run_line(input int l, input int first = 0);
        for (int p = first; p < 648; p++) step(l, p < 642 ? p : p < 646 ? 656 + p - 642 : 798 + p - 646);
    endtask

    task automatic run_frame();
        for (int l = 0; l < 6; l++) run_line(l);
        for (int l = 474; l < 480; l++) run_line(l);
        run_line(490);
        for (int l = 522; l < 525; l++) run_line(l);
    endtask

    // compare process: outputs at this sample reflect the inputs seen one sample earlier
    initial begin
        bit have = 0;
        bit p_hs, p_vs, p_de, p_valid;
        int p_x, p_y, p_exp;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                chk("rst_hsync", out_hsync, 0);
                chk("rst_vsync", out_vsync, 0);
                chk("rst_de", out_de, 0);
                chk("rst_rgb", out_rgb, 0);
                chk("rst_req", mem_req, 0);
                chk("rst_addr", mem_addr, 0);
                chk("rst_underrun", underrun, 0);
                have = 0;
            end else begin
                if (have) begin
                    chk("hsync", out_hsync, p_hs);
                    chk("vsync", out_vsync, p_vs);
                    chk("de", out_de, p_de);
                    if (p_de) begin
                        if (p_valid) chk("rgb", out_rgb, p_exp);
                        if (p_y == 2) l2[p_x] = int'(out_rgb);
                        if (p_y == 3) l3[p_x] = int'(out_rgb);
                        if (p_y == 5 && p_x == 7) pin_a = int'(out_rgb);
                        if (p_y == 479 && p_x == 639) pin_b = int'(out_rgb);
                    end else chk("rgb_blank", out_rgb, 0);
                end
                chk("underrun", underrun, exp_ur);
                p_hs = vga_hsync;
                p_vs = vga_vsync;
                p_de = vga_de;
                p_x = int'(vga_pixel);
                p_y = int'(vga_line);
                p_valid = bank_row[(p_y >> 1) % 2] == (p_y >> 1);
                p_exp = ((p_x >> 1) + (p_y >> 1)) & 255;
                have = 1;
            end
        end
    end

    initial begin
        int md, mp;
        rst_hold = 4;
        for (int p = 780; p < 800; p++) step(523, p);
        run_line(524);
        repeat (3) run_frame();
        md = 0;
        mp = 0;
        for (int k = 0; k < 640; k++) if (l2[k] != l3[k]) md++;
        for (int k = 0; k < 320; k++) if (l2[2*k] != l2[2*k+1]) mp++;
        chk("dbl_lines", md, 0);
        chk("dbl_pairs", mp, 0);
        chk("pin_x10_y2", l2[10], 6);
        chk("pin_x639_y3", l3[639], 64);
        chk("pin_x7_y5", pin_a, 5);
        chk("pin_x639_y479", pin_b, 46);
        gmode = 1;
        lat = 20;
        run_frame();
        chk("bp_underrun", underrun, 0);
        gmode = 0;
        lat = 1;
        for (int l = 94; l < 100; l++) run_line(l);
        gmode = 2;
        run_line(100);
        run_line(101);
        chk("ur_before_102", underrun, 0);
        step(102, 0);
        step(102, 1);
        chk("ur_at_102", underrun, 1);
        run_line(102, 2);
        run_line(103);
        chk("ur_sticky", underrun, 1);
        gmode = 0;
        rst_hold = 3;
        run_line(105);
        chk("ur_cleared", underrun, 0);
        run_line(106);
        run_line(107);
        arm37 = 1;
        for (int l = 8; l < 13; l++) run_line(l);
        run_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
